uart_rx: RTL and testbench

//  Bus-mapped 8N1 serial receiver for the 6809 CPLD: RX companion to the TX-only UARTs at $C0xx/$C1xx.

---
 rtl/uart_rx.sv | 137 +++++++++++++
 tb/tb_uart_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: bus-mapped 8N1 receiver with a one-deep holding register.
// RXD is synchronized, the start bit is qualified at mid-bit, and each data
// bit and the stop bit are then sampled one bit period apart. RDRF/OVR/FE
// and IE live in a small register file read over DATA and written via W.
module uart_rx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ADDR,
  inout  wire  [7:0] DATA,
  input  logic       R,
  input  logic       W,
  input  logic       RXD,
  output logic       IRQ
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          rxs;
  logic [1:0]    vld_pipe;
  logic          armed;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    hold;
  logic          rdrf, ovr, fe, ie;
  logic          r_q, w_q, raddr, waddr;
  logic [7:0]    wdat;
  logic [7:0]    rd_data;
  logic          busy, tick_half, tick_bit;
  logic          stop_good, stop_bad, rd0_done, wr1_done;

  assign rxs       = sync[1];
  assign busy      = (state != S_IDLE);
  assign tick_half = (cnt == HALF_M1);
  assign tick_bit  = (cnt == FULL_M1);
  assign stop_good = (state == S_STOP) && tick_bit &&  rxs;
  assign stop_bad  = (state == S_STOP) && tick_bit && !rxs;
  // A completed access is a low strobe seen on the previous edge, high now.
  assign rd0_done  = !r_q && R && !raddr;
  assign wr1_done  = !w_q && W &&  waddr;

  // Two-flop synchronizer. vld_pipe marks when rxs reflects the real pin;
  // armed then requires one genuine idle-high sample, so a line that is low
  // when reset releases cannot start a frame without a fresh falling edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync     <= 2'b11;
      vld_pipe <= '0;
      armed    <= 1'b0;
    end else begin
      sync     <= {sync[0], RXD};
      vld_pipe <= {vld_pipe[0], 1'b1};
      if (vld_pipe[1] && rxs) armed <= 1'b1;
    end
  end

  // Receive FSM: bit timing counter, data shift register, break wait.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        S_IDLE: if (armed && !rxs) begin
          state <= S_START;
          cnt   <= '0;
        end
        S_START: if (tick_half) begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= rxs ? S_IDLE : S_DATA;
        end else cnt <= cnt + 1'b1;
        S_DATA: if (tick_bit) begin
          cnt     <= '0;
          shift   <= {rxs, shift[7:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= S_STOP;
        end else cnt <= cnt + 1'b1;
        S_STOP: if (tick_bit) begin
          cnt   <= '0;
          state <= rxs ? S_IDLE : S_BREAK;
        end else cnt <= cnt + 1'b1;
        S_BREAK: if (rxs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus strobe tracking and status flags. Sets take priority over clears;
  // a data read completing on the stop sample frees the holding register
  // for the new byte instead of flagging an overrun.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_q   <= 1'b1;
      w_q   <= 1'b1;
      raddr <= 1'b0;
      waddr <= 1'b0;
      wdat  <= '0;
      hold  <= '0;
      rdrf  <= 1'b0;
      ovr   <= 1'b0;
      fe    <= 1'b0;
      ie    <= 1'b0;
    end else begin
      r_q <= R;
      w_q <= W;
      if (!R) raddr <= ADDR;
      if (!W) begin
        waddr <= ADDR;
        wdat  <= DATA;
      end
      if (wr1_done) ie <= wdat[7];
      if (stop_good && (!rdrf || rd0_done)) hold <= shift;
      if (stop_good)     rdrf <= 1'b1;
      else if (rd0_done) rdrf <= 1'b0;
      if (stop_good && rdrf && !rd0_done)        ovr <= 1'b1;
      else if (rd0_done || (wr1_done && wdat[1])) ovr <= 1'b0;
      if (stop_bad)                    fe <= 1'b1;
      else if (wr1_done && wdat[2])    fe <= 1'b0;
    end
  end

  assign rd_data = ADDR ? {ie, 3'b000, busy, fe, ovr, rdrf} : hold;
  assign DATA    = R ? 8'bz : rd_data;
  assign IRQ     = ~(ie & (rdrf | ovr));

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenarios plus a randomized frame/read/write mix,
// checked against an event-level model of the receiver's register file.
module tb_uart_rx;
  localparam int CPB = 8;
  // RXD fall to RDRF visible: sync (2) + half bit + 9 bits + flag (1)
  localparam int LAT = 2 + CPB/2 + 9*CPB + 1;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       ADDR = 1'b0;
  logic       R = 1'b1;
  logic       W = 1'b1;
  logic       RXD = 1'b1;
  logic       IRQ;
  wire  [7:0] DATA;
  logic [7:0] tb_d = '0;
  logic       tb_drv = 1'b0;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] m_hold;
  logic       m_rdrf, m_ovr, m_fe, m_ie;

  assign DATA = tb_drv ? tb_d : 8'bz;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DATA(DATA),
    .R(R), .W(W), .RXD(RXD), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %02h exp %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_status(input logic busy);
    return {m_ie, 3'b000, busy, m_fe, m_ovr, m_rdrf};
  endfunction

  function automatic logic m_irq();
    return ~(m_ie & (m_rdrf | m_ovr));
  endfunction

  task automatic m_reset();
    m_hold = '0; m_rdrf = 0; m_ovr = 0; m_fe = 0; m_ie = 0;
  endtask

  task automatic m_frame(input logic [7:0] b, input logic good);
    if (!good)      m_fe = 1'b1;
    else if (m_rdrf) m_ovr = 1'b1;
    else begin m_hold = b; m_rdrf = 1'b1; end
  endtask

  task automatic m_wr1(input logic [7:0] d);
    m_ie = d[7];
    if (d[2]) m_fe = 1'b0;
    if (d[1]) m_ovr = 1'b0;
  endtask

  task automatic bus_rd(input logic a, output logic [7:0] d);
    @(posedge CLK); #1 ADDR = a; R = 1'b0;
    @(negedge CLK); d = DATA;
    @(posedge CLK); #1 R = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic bus_wr(input logic a, input logic [7:0] d);
    @(posedge CLK); #1 ADDR = a; tb_d = d; tb_drv = 1'b1; W = 1'b0;
    @(posedge CLK); #1 W = 1'b1; tb_drv = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic st_chk(input string tag, input logic busy);
    logic [7:0] d;
    bus_rd(1'b1, d);
    chk(tag, d, m_status(busy));
  endtask

  task automatic rd_hold(input string tag);
    logic [7:0] d;
    bus_rd(1'b0, d);
    chk(tag, d, m_hold);
    m_rdrf = 1'b0; m_ovr = 1'b0;
  endtask

  // start bit goes low just after the first edge; line left at idle_lvl
  task automatic send_frame(input logic [7:0] b, input logic stp, input logic idle_lvl);
    @(posedge CLK); #1 RXD = 1'b0;
    for (int k = 0; k < 8; k++) begin
      repeat (CPB) @(posedge CLK); #1 RXD = b[k];
    end
    repeat (CPB) @(posedge CLK); #1 RXD = stp;
    repeat (CPB) @(posedge CLK); #1 RXD = idle_lvl;
  endtask

  initial begin
    logic [7:0] d, b, a0;
    m_reset();
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;
    repeat (5) @(posedge CLK);
    #1;

    // 1: reset state, exact RDRF latency, read sequence
    st_chk("rst_status", 1'b0);
    chk("rst_irq", {7'b0, IRQ}, {7'b0, m_irq()});
    @(posedge CLK); #1 ADDR = 1'b1; R = 1'b0;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        @(posedge CLK);
        repeat (LAT - 1) @(posedge CLK);
        #1 chk("lat_pre", {7'b0, DATA[0]}, 8'h00);
        @(posedge CLK);
        #1 chk("lat_rdrf", {7'b0, DATA[0]}, 8'h01);
      end
    join
    R = 1'b1;
    repeat (2) @(posedge CLK); #1;
    m_frame(8'hA5, 1'b1);
    st_chk("t1_st", 1'b0);
    rd_hold("t1_data");
    st_chk("t1_st_clr", 1'b0);

    // 2: interrupt enable
    bus_wr(1'b1, 8'h80); m_wr1(8'h80);
    send_frame(8'h3C, 1'b1, 1'b1); m_frame(8'h3C, 1'b1);
    chk("t2_irq_lo", {7'b0, IRQ}, {7'b0, m_irq()});
    rd_hold("t2_data");
    chk("t2_irq_hi", {7'b0, IRQ}, {7'b0, m_irq()});

    // 3: overrun
    send_frame(8'h11, 1'b1, 1'b1); m_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1); m_frame(8'h22, 1'b1);
    st_chk("t3_ovr", 1'b0);
    chk("t3_irq", {7'b0, IRQ}, {7'b0, m_irq()});
    rd_hold("t3_data");
    st_chk("t3_clr", 1'b0);

    // 4: framing error, line held low (break)
    send_frame(8'h55, 1'b0, 1'b0); m_frame(8'h55, 1'b0);
    st_chk("t4_fe", 1'b1);
    repeat (40 * CPB) @(posedge CLK); #1;
    st_chk("t4_brk", 1'b1);
    RXD = 1'b1;
    repeat (6) @(posedge CLK); #1;
    st_chk("t4_idle", 1'b0);
    bus_wr(1'b1, 8'h04); m_wr1(8'h04);
    st_chk("t4_feclr", 1'b0);

    // 5: glitch rejection, then reset mid-frame
    @(posedge CLK); #1 RXD = 1'b0;
    repeat (3) @(posedge CLK); #1 RXD = 1'b1;
    repeat (12) @(posedge CLK); #1;
    st_chk("t5_glitch", 1'b0);
    send_frame(8'h42, 1'b1, 1'b1); m_frame(8'h42, 1'b1);
    @(posedge CLK); #1 RXD = 1'b0;
    repeat (20) @(posedge CLK); #1 RESET = 1'b0;
    repeat (3) @(posedge CLK); #1 RESET = 1'b1;
    m_reset();
    repeat (30) @(posedge CLK); #1;
    st_chk("t5_rst_low", 1'b0);
    RXD = 1'b1;
    repeat (10) @(posedge CLK); #1;
    send_frame(8'h7E, 1'b1, 1'b1); m_frame(8'h7E, 1'b1);
    st_chk("t5_st", 1'b0);
    rd_hold("t5_data");

    // 6: data read completing on the same edge as the stop sample
    a0 = 8'($urandom);
    send_frame(a0, 1'b1, 1'b1); m_frame(a0, 1'b1);
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b1); m_frame(b, 1'b1);
    fork
      send_frame(8'h99, 1'b1, 1'b1);
      begin
        @(posedge CLK);
        repeat (LAT - 2) @(posedge CLK);
        #1 ADDR = 1'b0; R = 1'b0;
        @(negedge CLK); d = DATA;
        @(posedge CLK); #1 R = 1'b1;
      end
    join
    chk("t6_old", d, m_hold);
    m_hold = 8'h99; m_rdrf = 1'b1; m_ovr = 1'b0;
    repeat (2) @(posedge CLK); #1;
    st_chk("t6_st", 1'b0);
    rd_hold("t6_data");

    // randomized mix of frames, reads and control writes
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        send_frame(b, 1'b0, 1'b1); m_frame(b, 1'b0);
      end else begin
        send_frame(b, 1'b1, 1'b1); m_frame(b, 1'b1);
      end
      repeat (6) @(posedge CLK); #1;
      if ($urandom_range(0, 1) == 1) rd_hold("rnd_data");
      if ($urandom_range(0, 3) == 0) begin
        d = 8'($urandom);
        bus_wr(1'b1, d); m_wr1(d);
      end
      st_chk("rnd_st", 1'b0);
      chk("rnd_irq", {7'b0, IRQ}, {7'b0, m_irq()});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
